bip2_control_unit: RTL and testbench
====================================

Name: bip2_control_unit

Overview:
Multi-cycle sequencer for the BIP2 datapath. It holds the program counter, instruction register and the latched Z/N status flags. It decodes 16-bit instructions into per-cycle strobes for the accumulator, the data memory and the add/sub ALU (op 0 = add, 1 = sub). It sits between instruction memory and the datapath, and uses 2 cycles per instruction (FETCH, EXEC).

Parameters:
DATA_WIDTH, 16, instruction word width
ADDR_WIDTH, 11, PC, operand and data address width; operand = instr[ADDR_WIDTH-1:0]
OPCODE_WIDTH, 5, opcode field = instr[DATA_WIDTH-1 -: OPCODE_WIDTH]
RESET_PC, 0, PC value loaded on reset

Ports:
clock_in  input  1  single system clock; all state updates on rising edge
reset_in  input  1  synchronous, active-high reset
instr_in  input  DATA_WIDTH  instruction memory read data at address pc_out (asynchronous read)
alu_Z_in  input  1  ALU zero flag, combinational, valid during EXEC
alu_N_in  input  1  ALU negative flag, combinational, valid during EXEC
pc_out  output  ADDR_WIDTH  current PC, drives instruction memory address
operand_out  output  ADDR_WIDTH  IR operand field; used as data address, immediate and branch target
data_wr_out  output  1  data memory write strobe (STO)
acc_load_out  output  1  accumulator load enable
acc_sel_out  output  2  accumulator source: 00 ALU, 01 data memory, 10 immediate
alu_op_out  output  1  0 = add, 1 = sub
alu_src_out  output  1  ALU B source: 0 = data memory, 1 = immediate
halt_out  output  1  high while in HALT

Behaviour:
- Reset (any state, any cycle): state = FETCH, PC = RESET_PC, IR = 0, Z = 0, N = 0. All strobes are 0, halt_out = 0, and they take effect at the next edge.
- FETCH: IR <= instr_in. All strobes are 0. Next state is EXEC.
- EXEC: strobes are decoded combinationally from IR and asserted for exactly this one cycle. At the cycle-ending edge the PC updates, the flags update and the next state is taken.
- Outside EXEC, data_wr_out, acc_load_out, alu_op_out and alu_src_out are 0, and acc_sel_out = 00.
- operand_out always reflects IR[ADDR_WIDTH-1:0].
- Opcodes; each does PC+1 unless stated:
  - 00000 HLT: no strobes; next state HALT; PC unchanged.
  - 00001 STO: data_wr_out = 1.
  - 00010 LD: acc_load_out = 1, acc_sel_out = 01.
  - 00011 LDI: acc_load_out = 1, acc_sel_out = 10.
  - 00100 ADD: acc_load_out = 1, acc_sel_out = 00, alu_op_out = 0, alu_src_out = 0.
  - 00101 ADDI: same as ADD but alu_src_out = 1.
  - 00110 SUB: same as ADD but alu_op_out = 1.
  - 00111 SUBI: alu_op_out = 1, alu_src_out = 1.
  - 01000 BEQ: taken if Z.
  - 01001 BNE: taken if !Z.
  - 01010 BGT: taken if !Z & !N.
  - 01011 BGE: taken if !N.
  - 01100 BLT: taken if N.
  - 01101 BLE: taken if Z | N.
  - 01110 JMP: always taken.
  - All other opcodes: NOP (see Optional Feature).
- Taken branch: PC <= operand (absolute). Not taken: PC <= PC+1.
- PC+1 wraps modulo 2^ADDR_WIDTH (0x7FF -> 0x000).
- Flags: Z and N latch alu_Z_in / alu_N_in at the end of EXEC only for ADD/ADDI/SUB/SUBI. All other instructions hold the flags. A branch immediately after an arithmetic instruction sees the updated flags.
- HALT: absorbing state. halt_out = 1, all strobes 0, PC/IR/flags frozen. Only reset exits.
- Throughput is fixed at 2 cycles per instruction. There are no stalls or handshakes.

Optional Feature:
Macro BIP2_CTRL_ILLEGAL_TRAP_EN.
- Defined: adds an output port illegal_out (1 bit). An undefined opcode in EXEC drives no strobes, holds the PC and enters HALT. illegal_out is then 1, stays set until reset, and reset clears it.
- Undefined: the port does not exist, and undefined opcodes execute as NOP with PC+1.

Test Plan:
- Reset, then release: pc_out = 0x000; first edge is FETCH; EXEC at cycle 2; halt_out = 0. Assert reset during an EXEC of STO -> next cycle data_wr_out = 0, pc_out = 0.
- LDI 5 at address 0: FETCH then EXEC -> acc_load_out = 1, acc_sel_out = 10, operand_out = 0x005; pc_out = 0x001 after EXEC.
- SUBI 5 with alu_Z_in = 1, alu_N_in = 0 in EXEC -> alu_op_out = 1, alu_src_out = 1. Then BEQ 0x040 -> pc_out = 0x040. The same BEQ with Z = 0 -> pc_out = PC+1.
- ADD with N = 1 latched, then LD (flags held), then BLT 0x123 -> taken, pc_out = 0x123. BGE 0x123 from the same flags -> not taken.
- JMP 0x7FF, then NOP at 0x7FF -> pc_out wraps to 0x000.
- HLT -> halt_out = 1; pc_out is frozen for 10 cycles with all strobes 0. Opcode 11111: with BIP2_CTRL_ILLEGAL_TRAP_EN -> illegal_out = 1 and halt. Without the macro -> PC+1, no strobes.

Source files
------------

// File: rtl/bip2_control_unit.sv
// BIP2 control unit: PC, IR and Z/N flags, sequenced FETCH -> EXEC (2 cycles per instruction).
// Optional BIP2_CTRL_ILLEGAL_TRAP_EN: undefined opcodes halt and raise illegal_out instead of acting as NOP.
module bip2_control_unit #(
    parameter int DATA_WIDTH   = 16,
    parameter int ADDR_WIDTH   = 11,
    parameter int OPCODE_WIDTH = 5,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC = '0
) (
    input  logic                  clock_in,
    input  logic                  reset_in,
    input  logic [DATA_WIDTH-1:0] instr_in,
    input  logic                  alu_Z_in,
    input  logic                  alu_N_in,
    output logic [ADDR_WIDTH-1:0] pc_out,
    output logic [ADDR_WIDTH-1:0] operand_out,
    output logic                  data_wr_out,
    output logic                  acc_load_out,
    output logic [1:0]            acc_sel_out,
    output logic                  alu_op_out,
    output logic                  alu_src_out,
`ifdef BIP2_CTRL_ILLEGAL_TRAP_EN
    output logic                  illegal_out,
`endif
    output logic                  halt_out
);

    typedef enum logic [1:0] {
        ST_FETCH = 2'b00,
        ST_EXEC  = 2'b01,
        ST_HALT  = 2'b10
    } state_t;

    localparam logic [OPCODE_WIDTH-1:0] OP_HLT  = OPCODE_WIDTH'(0);
    localparam logic [OPCODE_WIDTH-1:0] OP_STO  = OPCODE_WIDTH'(1);
    localparam logic [OPCODE_WIDTH-1:0] OP_LD   = OPCODE_WIDTH'(2);
    localparam logic [OPCODE_WIDTH-1:0] OP_LDI  = OPCODE_WIDTH'(3);
    localparam logic [OPCODE_WIDTH-1:0] OP_ADD  = OPCODE_WIDTH'(4);
    localparam logic [OPCODE_WIDTH-1:0] OP_ADDI = OPCODE_WIDTH'(5);
    localparam logic [OPCODE_WIDTH-1:0] OP_SUB  = OPCODE_WIDTH'(6);
    localparam logic [OPCODE_WIDTH-1:0] OP_SUBI = OPCODE_WIDTH'(7);
    localparam logic [OPCODE_WIDTH-1:0] OP_BEQ  = OPCODE_WIDTH'(8);
    localparam logic [OPCODE_WIDTH-1:0] OP_BNE  = OPCODE_WIDTH'(9);
    localparam logic [OPCODE_WIDTH-1:0] OP_BGT  = OPCODE_WIDTH'(10);
    localparam logic [OPCODE_WIDTH-1:0] OP_BGE  = OPCODE_WIDTH'(11);
    localparam logic [OPCODE_WIDTH-1:0] OP_BLT  = OPCODE_WIDTH'(12);
    localparam logic [OPCODE_WIDTH-1:0] OP_BLE  = OPCODE_WIDTH'(13);
    localparam logic [OPCODE_WIDTH-1:0] OP_JMP  = OPCODE_WIDTH'(14);

    localparam logic [1:0] SEL_ALU = 2'b00;
    localparam logic [1:0] SEL_MEM = 2'b01;
    localparam logic [1:0] SEL_IMM = 2'b10;

    state_t                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   pc_q, pc_d;
    logic [DATA_WIDTH-1:0]   ir_q, ir_d;
    logic                    z_q, z_d;
    logic                    n_q, n_d;
    logic                    illegal_q, illegal_d;

    logic [OPCODE_WIDTH-1:0] opcode;
    logic [ADDR_WIDTH-1:0]   operand;
    logic [ADDR_WIDTH-1:0]   pc_inc;
    logic                    arith;
    logic                    is_branch;
    logic                    br_cond;

    assign opcode      = ir_q[DATA_WIDTH-1 -: OPCODE_WIDTH];
    assign operand     = ir_q[ADDR_WIDTH-1:0];
    assign pc_inc      = pc_q + {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
    assign pc_out      = pc_q;
    assign operand_out = operand;
    assign halt_out    = (state_q == ST_HALT);

`ifdef BIP2_CTRL_ILLEGAL_TRAP_EN
    assign illegal_out = illegal_q;
`endif

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        ir_d         = ir_q;
        z_d          = z_q;
        n_d          = n_q;
        illegal_d    = illegal_q;
        data_wr_out  = 1'b0;
        acc_load_out = 1'b0;
        acc_sel_out  = SEL_ALU;
        alu_op_out   = 1'b0;
        alu_src_out  = 1'b0;
        arith        = 1'b0;
        is_branch    = 1'b0;
        br_cond      = 1'b0;

        case (state_q)
            ST_FETCH: begin
                ir_d    = instr_in;
                state_d = ST_EXEC;
            end

            ST_EXEC: begin
                state_d = ST_FETCH;
                pc_d    = pc_inc;
                case (opcode)
                    OP_HLT: begin
                        pc_d    = pc_q;
                        state_d = ST_HALT;
                    end
                    OP_STO: data_wr_out = 1'b1;
                    OP_LD: begin
                        acc_load_out = 1'b1;
                        acc_sel_out  = SEL_MEM;
                    end
                    OP_LDI: begin
                        acc_load_out = 1'b1;
                        acc_sel_out  = SEL_IMM;
                    end
                    OP_ADD, OP_ADDI, OP_SUB, OP_SUBI: begin
                        acc_load_out = 1'b1;
                        acc_sel_out  = SEL_ALU;
                        alu_op_out   = (opcode == OP_SUB) || (opcode == OP_SUBI);
                        alu_src_out  = (opcode == OP_ADDI) || (opcode == OP_SUBI);
                        arith        = 1'b1;
                    end
                    OP_BEQ: begin is_branch = 1'b1; br_cond = z_q;           end
                    OP_BNE: begin is_branch = 1'b1; br_cond = !z_q;          end
                    OP_BGT: begin is_branch = 1'b1; br_cond = !z_q && !n_q;  end
                    OP_BGE: begin is_branch = 1'b1; br_cond = !n_q;          end
                    OP_BLT: begin is_branch = 1'b1; br_cond = n_q;           end
                    OP_BLE: begin is_branch = 1'b1; br_cond = z_q || n_q;    end
                    OP_JMP: begin is_branch = 1'b1; br_cond = 1'b1;          end
                    default: begin
`ifdef BIP2_CTRL_ILLEGAL_TRAP_EN
                        pc_d      = pc_q;
                        state_d   = ST_HALT;
                        illegal_d = 1'b1;
`endif
                    end
                endcase

                if (is_branch && br_cond) begin
                    pc_d = operand;
                end
                // Flags only follow the ALU for arithmetic; everything else keeps the last result.
                if (arith) begin
                    z_d = alu_Z_in;
                    n_d = alu_N_in;
                end
            end

            ST_HALT: state_d = ST_HALT;

            default: state_d = ST_FETCH;
        endcase
    end

    always_ff @(posedge clock_in) begin
        if (reset_in) begin
            state_q   <= ST_FETCH;
            pc_q      <= RESET_PC;
            ir_q      <= '0;
            z_q       <= 1'b0;
            n_q       <= 1'b0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            ir_q      <= ir_d;
            z_q       <= z_d;
            n_q       <= n_d;
            illegal_q <= illegal_d;
        end
    end

endmodule

// File: tb/tb_bip2_control_unit.sv
// Bench for bip2_control_unit: instruction-level reference model checked every cycle,
// a directed program with literal expectations, then randomized programs and resets.
module tb_bip2_control_unit;

    logic        clk;
    logic        reset_in;
    logic [15:0] instr_in;
    logic        alu_Z_in;
    logic        alu_N_in;
    logic [10:0] pc_out;
    logic [10:0] operand_out;
    logic        data_wr_out;
    logic        acc_load_out;
    logic [1:0]  acc_sel_out;
    logic        alu_op_out;
    logic        alu_src_out;
    logic        halt_out;
`ifdef BIP2_CTRL_ILLEGAL_TRAP_EN
    logic        illegal_out;
`endif

    logic [15:0] imem [2048];

    int n_vec = 0;
    int n_err = 0;

    // Reference model: phase 0 = fetch, 1 = execute, 2 = halted
    int          m_phase;
    logic [10:0] m_pc;
    logic [15:0] m_ir;
    logic        m_z, m_n, m_ill;

    bip2_control_unit dut (
        .clock_in     (clk),
        .reset_in     (reset_in),
        .instr_in     (instr_in),
        .alu_Z_in     (alu_Z_in),
        .alu_N_in     (alu_N_in),
        .pc_out       (pc_out),
        .operand_out  (operand_out),
        .data_wr_out  (data_wr_out),
        .acc_load_out (acc_load_out),
        .acc_sel_out  (acc_sel_out),
        .alu_op_out   (alu_op_out),
        .alu_src_out  (alu_src_out),
`ifdef BIP2_CTRL_ILLEGAL_TRAP_EN
        .illegal_out  (illegal_out),
`endif
        .halt_out     (halt_out)
    );

    assign instr_in = imem[pc_out];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [15:0] mk(input int op, input int opnd);
        logic [4:0]  o;
        logic [10:0] a;
        o = 5'(op);
        a = 11'(opnd);
        return {o, a};
    endfunction

    function automatic bit is_defined(input int op);
        return op <= 14;
    endfunction

    // {data_wr, acc_load, acc_sel[1:0], alu_op, alu_src} during execute
    function automatic logic [5:0] exp_strobes(input int op);
        case (op)
            1:       return 6'b10_00_00;
            2:       return 6'b01_01_00;
            3:       return 6'b01_10_00;
            4:       return 6'b01_00_00;
            5:       return 6'b01_00_01;
            6:       return 6'b01_00_10;
            7:       return 6'b01_00_11;
            default: return 6'b00_00_00;
        endcase
    endfunction

    function automatic bit taken(input int op, input logic z, input logic n);
        case (op)
            8:       return z;
            9:       return !z;
            10:      return !z && !n;
            11:      return !n;
            12:      return n;
            13:      return z || n;
            14:      return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    task automatic check(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_update();
        int op;
        op = int'(m_ir[15:11]);
        if (reset_in) begin
            m_phase = 0; m_pc = 11'h000; m_ir = '0; m_z = 0; m_n = 0; m_ill = 0;
        end else if (m_phase == 0) begin
            m_ir    = imem[m_pc];
            m_phase = 1;
        end else if (m_phase == 1) begin
            if (op == 0) begin
                m_phase = 2;
`ifdef BIP2_CTRL_ILLEGAL_TRAP_EN
            end else if (!is_defined(op)) begin
                m_phase = 2;
                m_ill   = 1;
`endif
            end else begin
                if (op >= 4 && op <= 7) begin
                    m_z = alu_Z_in;
                    m_n = alu_N_in;
                end
                if (taken(op, m_z, m_n)) m_pc = m_ir[10:0];
                else                     m_pc = 11'((int'(m_pc) + 1) % 2048);
                m_phase = 0;
            end
        end
    endtask

    task automatic compare_all();
        logic [5:0] s;
        s = (m_phase == 1) ? exp_strobes(int'(m_ir[15:11])) : 6'b0;
        check("pc_out",       int'(pc_out),       int'(m_pc));
        check("operand_out",  int'(operand_out),  int'(m_ir[10:0]));
        check("halt_out",     int'(halt_out),     (m_phase == 2) ? 1 : 0);
        check("data_wr_out",  int'(data_wr_out),  int'(s[5]));
        check("acc_load_out", int'(acc_load_out), int'(s[4]));
        check("acc_sel_out",  int'(acc_sel_out),  int'(s[3:2]));
        check("alu_op_out",   int'(alu_op_out),   int'(s[1]));
        check("alu_src_out",  int'(alu_src_out),  int'(s[0]));
`ifdef BIP2_CTRL_ILLEGAL_TRAP_EN
        check("illegal_out",  int'(illegal_out),  int'(m_ill));
`endif
    endtask

    task automatic step();
        @(posedge clk);
        model_update();
        @(negedge clk);
        compare_all();
    endtask

    task automatic set_flags(input logic z, input logic n);
        alu_Z_in = z;
        alu_N_in = n;
    endtask

    initial begin
        int halt_cnt;
        for (int i = 0; i < 2048; i++) imem[i] = mk(15, 0);
        imem[11'h000] = mk(3, 5);        // LDI 5
        imem[11'h001] = mk(7, 5);        // SUBI 5
        imem[11'h002] = mk(8, 11'h040);  // BEQ 0x040
        imem[11'h040] = mk(7, 5);        // SUBI 5
        imem[11'h041] = mk(8, 11'h040);  // BEQ 0x040
        imem[11'h042] = mk(4, 11'h010);  // ADD
        imem[11'h043] = mk(2, 11'h010);  // LD
        imem[11'h044] = mk(12, 11'h123); // BLT 0x123
        imem[11'h123] = mk(11, 11'h123); // BGE 0x123
        imem[11'h124] = mk(14, 11'h7FF); // JMP 0x7FF
        imem[11'h7FF] = mk(31, 0);       // undefined opcode

        reset_in = 1'b1;
        set_flags(0, 0);
        @(negedge clk);
        step();
        step();
        check("reset pc", int'(pc_out), 0);
        check("reset halt", int'(halt_out), 0);
        reset_in = 1'b0;

        step();
        check("LDI acc_load", int'(acc_load_out), 1);
        check("LDI acc_sel", int'(acc_sel_out), 2);
        check("LDI operand", int'(operand_out), 5);
        step();
        check("LDI next pc", int'(pc_out), 1);

        set_flags(1, 0);
        step();
        check("SUBI alu_op", int'(alu_op_out), 1);
        check("SUBI alu_src", int'(alu_src_out), 1);
        step();
        step(); step();
        check("BEQ taken pc", int'(pc_out), 11'h040);

        set_flags(0, 0);
        step(); step();
        step(); step();
        check("BEQ not taken pc", int'(pc_out), 11'h042);

        set_flags(0, 1);
        step(); step();
        set_flags(1, 0);
        step(); step();
        step(); step();
        check("BLT taken pc", int'(pc_out), 11'h123);
        step(); step();
        check("BGE not taken pc", int'(pc_out), 11'h124);
        step(); step();
        check("JMP pc", int'(pc_out), 11'h7FF);
        step();
        check("undef data_wr", int'(data_wr_out), 0);
        check("undef acc_load", int'(acc_load_out), 0);
        step();
`ifdef BIP2_CTRL_ILLEGAL_TRAP_EN
        check("undef trap pc", int'(pc_out), 11'h7FF);
        check("undef trap halt", int'(halt_out), 1);
        check("undef trap illegal", int'(illegal_out), 1);
`else
        check("wrap pc", int'(pc_out), 0);
        check("undef halt", int'(halt_out), 0);
`endif

        imem[0] = mk(1, 7);  // STO 7
        imem[1] = mk(0, 0);  // HLT
        reset_in = 1'b1;
        step();
        reset_in = 1'b0;
        step();
        check("STO data_wr", int'(data_wr_out), 1);
        reset_in = 1'b1;
        step();
        check("reset in EXEC data_wr", int'(data_wr_out), 0);
        check("reset in EXEC pc", int'(pc_out), 0);
        reset_in = 1'b0;
        step(); step();
        step(); step();
        check("HLT halt", int'(halt_out), 1);
        for (int i = 0; i < 10; i++) begin
            step();
            check("HLT frozen pc", int'(pc_out), 1);
            check("HLT no acc_load", int'(acc_load_out), 0);
        end

        for (int i = 0; i < 2048; i++) begin
            int op;
            op = int'($urandom_range(0, 31));
            if (op == 0 && $urandom_range(0, 7) != 0) op = 1;
`ifdef BIP2_CTRL_ILLEGAL_TRAP_EN
            if (op > 14 && $urandom_range(0, 3) != 0) op = int'($urandom_range(1, 14));
`endif
            imem[i] = mk(op, int'($urandom_range(0, 2047)));
        end
        reset_in = 1'b1;
        step();
        reset_in = 1'b0;
        halt_cnt = 0;
        for (int c = 0; c < 4000; c++) begin
            set_flags(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            halt_cnt = (m_phase == 2) ? halt_cnt + 1 : 0;
            reset_in = (halt_cnt > 3) || ($urandom_range(0, 199) == 0);
            if (reset_in) halt_cnt = 0;
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
